// File: rtl/io_seg7_pkg.sv
// Shared types and constants for the 7-segment display block.
package io_seg7_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned BCD_W = 40;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns; entry 0 is the rightmost literal.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/io_seg7_display_if.sv
// Output-port bus between the computer core (master) and the display driver (slave).
interface io_seg7_display_if #(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned VAL_W      = 32
);
  logic [VAL_W-1:0]      out_port0;
  logic [VAL_W-1:0]      out_port1;
  logic [VAL_W-1:0]      out_port2;
  logic [VAL_W-1:0]      out_port3;
  logic [1:0]            sel;
  logic                  hex_mode;
  logic [6:0]            seg;
  logic [NUM_DIGITS-1:0] an;
  logic                  busy;
  logic                  ovf;

  modport master (
    output out_port0, out_port1, out_port2, out_port3, sel, hex_mode,
    input  seg, an, busy, ovf
  );

  modport slave (
    input  out_port0, out_port1, out_port2, out_port3, sel, hex_mode,
    output seg, an, busy, ovf
  );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift-and-adjust iteration per clock.
module bin2bcd_seq
  import io_seg7_pkg::*;
#(
  parameter int unsigned VAL_W = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             start,
  input  logic [VAL_W-1:0] value,
  output logic             busy,
  output logic             done,
  output logic [BCD_W-1:0] bcd
);

  localparam int unsigned CNT_W = $clog2(VAL_W);

  logic [VAL_W-1:0] shreg;
  logic [CNT_W-1:0] cnt;
  logic [BCD_W-1:0] adj;

  // Add 3 to every BCD nibble that would overflow past 9 after the shift.
  always_comb begin
    adj = bcd;
    for (int i = 0; i < int'(BCD_W / 4); i++) begin
      if (bcd[4*i +: 4] >= 4'd5) adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // done is high during the final iteration so the caller can step to its result state.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      shreg <= '0;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else if (start) begin
      shreg <= value;
      bcd   <= '0;
      cnt   <= '0;
      busy  <= 1'b1;
      done  <= 1'b0;
    end else if (busy) begin
      {bcd, shreg} <= {adj[BCD_W-2:0], shreg, 1'b0};
      cnt          <= cnt + CNT_W'(1);
      done         <= (cnt == CNT_W'(VAL_W - 2));
      if (cnt == CNT_W'(VAL_W - 1)) busy <= 1'b0;
    end else begin
      done <= 1'b0;
    end
  end

endmodule

// File: rtl/io_seg7_display.sv
// Multiplexed 7-segment driver for the computer's output ports (hex or decimal).
// Optional leading-zero blanking is enabled by defining IO_SEG7_LZB_EN.
module io_seg7_display
  import io_seg7_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 8,
  parameter int unsigned SCAN_DIV   = 50000,
  parameter int unsigned VAL_W      = 32
) (
  input  logic        clock,
  input  logic        resetn,
  io_seg7_display_if.slave bus
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned CNT_W = $clog2(SCAN_DIV);

  state_t                     state, state_nxt;
  logic [VAL_W-1:0]           v, cap_val;
  logic                       cap_mode;
  logic                       changed, start, load_hex;
  logic [NUM_DIGITS-1:0][3:0] digit;
  logic [NUM_DIGITS-1:0]      blank;
  logic                       busy_r, ovf_r;
  logic [CNT_W-1:0]           scan_cnt;
  logic [IDX_W-1:0]           idx;
  logic [NUM_DIGITS-1:0]      an_r;
  logic [6:0]                 seg_r, seg_c;
  logic                       eng_busy, eng_done;
  logic [BCD_W-1:0]           eng_bcd;

  always_comb begin
    unique case (bus.sel)
      2'd0:    v = bus.out_port0;
      2'd1:    v = bus.out_port1;
      2'd2:    v = bus.out_port2;
      default: v = bus.out_port3;
    endcase
  end

  assign changed = (v != cap_val) || (bus.hex_mode != cap_mode);

  bin2bcd_seq #(.VAL_W(VAL_W)) u_bcd (
    .clock  (clock),
    .resetn (resetn),
    .start  (start),
    .value  (v),
    .busy   (eng_busy),
    .done   (eng_done),
    .bcd    (eng_bcd)
  );

  always_ff @(posedge clock) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    start     = 1'b0;
    load_hex  = 1'b0;
    unique case (state)
      IDLE: begin
        if (changed) begin
          if (bus.hex_mode) begin
            load_hex = 1'b1;
          end else begin
            start     = 1'b1;
            state_nxt = CONV;
          end
        end
      end
      CONV: begin
        if (eng_done)      state_nxt = DONE;
        else if (!eng_busy) state_nxt = IDLE;  // defensive recovery if the engine ever stalls
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      cap_val  <= '0;
      cap_mode <= 1'b0;
      digit    <= '0;
      busy_r   <= 1'b0;
      ovf_r    <= 1'b0;
    end else begin
      if (start) begin
        cap_val  <= v;
        cap_mode <= 1'b0;
        busy_r   <= 1'b1;
      end
      if (load_hex) begin
        cap_val  <= v;
        cap_mode <= 1'b1;
        ovf_r    <= 1'b0;
        for (int i = 0; i < int'(NUM_DIGITS); i++) digit[i] <= v[4*i +: 4];
      end
      if (state == DONE) begin
        for (int i = 0; i < int'(NUM_DIGITS); i++) digit[i] <= eng_bcd[4*i +: 4];
        ovf_r  <= |eng_bcd[BCD_W-1:32];
        busy_r <= 1'b0;
      end
    end
  end

`ifdef IO_SEG7_LZB_EN
  logic lzb_seen;
  // Blank every digit above the most significant nonzero one; digit 0 always shows.
  always_comb begin
    lzb_seen = 1'b0;
    blank    = '0;
    for (int i = int'(NUM_DIGITS) - 1; i > 0; i--) begin
      lzb_seen = lzb_seen | (digit[i] != 4'd0);
      blank[i] = ~lzb_seen;
    end
  end
`else
  assign blank = '0;
`endif

  assign seg_c = blank[idx] ? SEG_BLANK : SEG_TABLE[digit[idx]];

  always_ff @(posedge clock) begin
    if (!resetn) begin
      scan_cnt <= '0;
      idx      <= '0;
      an_r     <= '1;
      seg_r    <= SEG_BLANK;
    end else begin
      if (scan_cnt == CNT_W'(SCAN_DIV - 1)) begin
        scan_cnt <= '0;
        idx      <= (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      end else begin
        scan_cnt <= scan_cnt + CNT_W'(1);
      end
      an_r  <= ~(NUM_DIGITS'(1) << idx);
      seg_r <= seg_c;
    end
  end

  assign bus.seg  = seg_r;
  assign bus.an   = an_r;
  assign bus.busy = busy_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_io_seg7_display.sv
// Directed bench for io_seg7_display (SCAN_DIV=4); honours IO_SEG7_LZB_EN in its expectations.
module tb_io_seg7_display;

  logic clk = 1'b0;
  logic resetn;
  int   tests = 0;
  int   fails = 0;

  io_seg7_display_if #(.NUM_DIGITS(8), .VAL_W(32)) bus ();

  io_seg7_display #(.NUM_DIGITS(8), .SCAN_DIV(4), .VAL_W(32)) dut (
    .clock  (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  sel;
    logic        hex;
    logic [31:0] val;
    logic [31:0] digs;
    logic        ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] exp_seg(input logic [31:0] digs, input int i);
    logic [6:0] p;
`ifdef IO_SEG7_LZB_EN
    if (i > 0 && (digs >> (4 * i)) == 32'h0) return 7'h7F;
`endif
    case (digs[4*i +: 4])
      4'h0: p = 7'h40;  4'h1: p = 7'h79;  4'h2: p = 7'h24;  4'h3: p = 7'h30;
      4'h4: p = 7'h19;  4'h5: p = 7'h12;  4'h6: p = 7'h02;  4'h7: p = 7'h78;
      4'h8: p = 7'h00;  4'h9: p = 7'h10;  4'hA: p = 7'h08;  4'hB: p = 7'h03;
      4'hC: p = 7'h46;  4'hD: p = 7'h21;  4'hE: p = 7'h06;  default: p = 7'h0E;
    endcase
    return p;
  endfunction

  function automatic int an_idx(input logic [7:0] a);
    int r = -1;
    for (int i = 0; i < 8; i++) if (a == ~(8'h01 << i)) r = i;
    return r;
  endfunction

  task automatic drive(input logic [1:0] s, input logic h, input logic [31:0] val);
    case (s)
      2'd0:    bus.out_port0 = val;
      2'd1:    bus.out_port1 = val;
      2'd2:    bus.out_port2 = val;
      default: bus.out_port3 = val;
    endcase
    bus.sel      = s;
    bus.hex_mode = h;
  endtask

  // Observe one full scan (32 cycles) and compare each lit digit's segments.
  task automatic capture(input string tag, input logic [31:0] digs);
    logic [6:0] got [8];
    int k;
    for (int i = 0; i < 8; i++) got[i] = 7'bxxxxxxx;
    for (int c = 0; c < 32; c++) begin
      @(negedge clk);
      k = an_idx(bus.an);
      if (k >= 0) got[k] = bus.seg;
    end
    for (int i = 0; i < 8; i++) check($sformatf("%s_d%0d", tag, i), 32'(got[i]), 32'(exp_seg(digs, i)));
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (bus.busy !== 1'b0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_idle"}, 32'(bus.busy), 32'h0);
  endtask

  initial begin
    int busy_cnt;
    int lat;
    int k;

    vecs[0] = '{sel: 2'd0, hex: 1'b0, val: 32'd12345678,  digs: 32'h12345678, ovf: 1'b0};
    vecs[1] = '{sel: 2'd1, hex: 1'b0, val: 32'hFFFFFFFF,  digs: 32'h94967295, ovf: 1'b1};
    vecs[2] = '{sel: 2'd2, hex: 1'b1, val: 32'hDEADBEEF,  digs: 32'hDEADBEEF, ovf: 1'b0};
    vecs[3] = '{sel: 2'd3, hex: 1'b0, val: 32'd99999999,  digs: 32'h99999999, ovf: 1'b0};
    vecs[4] = '{sel: 2'd3, hex: 1'b0, val: 32'd100000000, digs: 32'h00000000, ovf: 1'b1};
    vecs[5] = '{sel: 2'd3, hex: 1'b1, val: 32'h0000002A,  digs: 32'h0000002A, ovf: 1'b0};
    vecs[6] = '{sel: 2'd0, hex: 1'b0, val: 32'd0,         digs: 32'h00000000, ovf: 1'b0};
    vecs[7] = '{sel: 2'd1, hex: 1'b1, val: 32'h0123ABCD,  digs: 32'h0123ABCD, ovf: 1'b0};

    resetn        = 1'b0;
    bus.out_port0 = '0;
    bus.out_port1 = '0;
    bus.out_port2 = '0;
    bus.out_port3 = '0;
    bus.sel       = 2'd0;
    bus.hex_mode  = 1'b0;

    // Reset state and first scan window after release.
    repeat (3) @(negedge clk);
    check("rst_seg",  32'(bus.seg),  32'h7F);
    check("rst_an",   32'(bus.an),   32'hFF);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_ovf",  32'(bus.ovf),  32'h0);
    resetn = 1'b1;
    @(negedge clk);
    check("rel_an",  32'(bus.an),  32'hFE);
    check("rel_seg", 32'(bus.seg), 32'(exp_seg(32'h0, 0)));
    capture("rst", 32'h0);

    for (int v = 0; v < 8; v++) begin
      drive(vecs[v].sel, vecs[v].hex, vecs[v].val);
      lat      = vecs[v].hex ? 1 : 34;
      busy_cnt = 0;
      for (int c = 1; c <= 40; c++) begin
        @(negedge clk);
        if (bus.busy === 1'b1) busy_cnt++;
        if (c == lat + 1) begin
          k = an_idx(bus.an);
          check($sformatf("v%0d_an", v), 32'(k >= 0), 32'h1);
          if (k >= 0) check($sformatf("v%0d_lat", v), 32'(bus.seg), 32'(exp_seg(vecs[v].digs, k)));
        end
      end
      check($sformatf("v%0d_busy", v), 32'(busy_cnt), vecs[v].hex ? 32'd0 : 32'd33);
      check($sformatf("v%0d_ovf", v), 32'(bus.ovf), 32'(vecs[v].ovf));
      capture($sformatf("v%0d", v), vecs[v].digs);
    end

    // Input change mid-conversion: first result is the captured value, then a re-conversion.
    drive(2'd0, 1'b0, 32'd100);
    @(negedge clk);
    check("mid_busy", 32'(bus.busy), 32'h1);
    repeat (9) @(negedge clk);
    bus.out_port0 = 32'd7;
    wait_idle("mid1");
    @(negedge clk);
    check("mid_reconv", 32'(bus.busy), 32'h1);
    capture("mid100", 32'h00000100);
    wait_idle("mid2");
    repeat (2) @(negedge clk);
    capture("mid7", 32'h00000007);
    check("mid_ovf", 32'(bus.ovf), 32'h0);

    // Reset mid-conversion aborts everything, then 42 converts after release.
    bus.out_port0 = 32'd42;
    repeat (15) @(negedge clk);
    check("rc_busy_pre", 32'(bus.busy), 32'h1);
    resetn = 1'b0;
    @(negedge clk);
    check("rc_busy", 32'(bus.busy), 32'h0);
    check("rc_an",   32'(bus.an),   32'hFF);
    check("rc_seg",  32'(bus.seg),  32'h7F);
    check("rc_ovf",  32'(bus.ovf),  32'h0);
    resetn = 1'b1;
    capture("rc_zero", 32'h0);
    wait_idle("rc");
    repeat (2) @(negedge clk);
    capture("rc42", 32'h00000042);
    check("rc42_ovf", 32'(bus.ovf), 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
